// File: rtl/timer_pkg.sv
// Shared constants for the machine timer peripheral: register offsets,
// CTRL bit positions and the compare register reset value.
package timer_pkg;

  // Byte offsets of the registers inside the 32-byte window
  localparam logic [4:0] OFF_MTIME_LO    = 5'h00;
  localparam logic [4:0] OFF_MTIME_HI    = 5'h04;
  localparam logic [4:0] OFF_MTIMECMP_LO = 5'h08;
  localparam logic [4:0] OFF_MTIMECMP_HI = 5'h0C;
  localparam logic [4:0] OFF_CTRL        = 5'h10;
  localparam logic [4:0] OFF_PRESCALE    = 5'h14;
  localparam logic [4:0] OFF_STATUS      = 5'h18;
  localparam logic [4:0] OFF_RSVD        = 5'h1C;

  // CTRL register bit positions
  localparam int CTRL_EN     = 0;
  localparam int CTRL_IRQ_EN = 1;

  // mtimecmp comes out of reset as far in the future as possible
  localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  // Word index (addr[4:2]) to byte offset; byte lanes are not decoded
  function automatic logic [4:0] word_off(input logic [2:0] idx);
    return {idx, 2'b00};
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler for the machine timer: holds the reload value and a down-counter
// that emits a one-cycle tick each time it passes through zero while enabled.
module timer_prescaler #(
  parameter int PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  load,
  input  logic [PRESCALE_W-1:0] load_val,
  output logic [PRESCALE_W-1:0] reload,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] reload_q, reload_d;
  logic [PRESCALE_W-1:0] cnt_q, cnt_d;

  // Tick when enabled and the counter sits at zero
  assign tick   = en && (cnt_q == '0);
  assign reload = reload_q;

  // Next-state: a reload write restarts the count, otherwise count down and wrap to the reload value
  always_comb begin
    reload_d = reload_q;
    cnt_d    = cnt_q;
    if (load) begin
      reload_d = load_val;
      cnt_d    = load_val;
    end else if (en) begin
      if (cnt_q == '0) cnt_d = reload_q;
      else             cnt_d = cnt_q - PRESCALE_W'(1);
    end
  end

  // Prescaler state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reload_q <= '0;
      cnt_q    <= '0;
    end else begin
      reload_q <= reload_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/timer_irq_unit.sv
// Memory-mapped machine timer: 64-bit mtime advanced by the prescaler tick,
// 64-bit mtimecmp, sticky PENDING flag and a level interrupt to the core.
module timer_irq_unit #(
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
  parameter int          PRESCALE_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  input  logic        re,
  output logic [31:0] rdata,
  output logic        hit,
  output logic        timer_irq
);

  import timer_pkg::*;

  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic [1:0]  ctrl_q, ctrl_d;
  logic        pending_q, pending_d;

  logic [4:0]            reg_off;
  logic                  wr_en;
  logic                  tick;
  logic                  match;
  logic                  pre_load;
  logic [PRESCALE_W-1:0] prescale;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^addr[1:0];

  // Window decode: the window is 32-byte aligned, so only addr[31:5] matter
  assign hit     = (addr[31:5] == BASE_ADDR[31:5]);
  assign reg_off = word_off(addr[4:2]);
  assign wr_en   = we && hit;
  assign pre_load = wr_en && (reg_off == OFF_PRESCALE);

  timer_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .en       (ctrl_q[CTRL_EN]),
    .load     (pre_load),
    .load_val (wdata[PRESCALE_W-1:0]),
    .reload   (prescale),
    .tick     (tick)
  );

  // Compare on registered values; the interrupt is the registered flag gated by the registered enable
  assign match     = (mtime_q >= mtimecmp_q);
  assign timer_irq = pending_q && ctrl_q[CTRL_IRQ_EN];

  // Register-bank next state; a write to either mtime half swallows a coincident tick and its carry
  always_comb begin
    mtime_d    = mtime_q + 64'(tick);
    mtimecmp_d = mtimecmp_q;
    ctrl_d     = ctrl_q;
    pending_d  = pending_q;
    if (wr_en) begin
      case (reg_off)
        OFF_MTIME_LO:    mtime_d = {mtime_q[63:32], wdata};
        OFF_MTIME_HI:    mtime_d = {wdata, mtime_q[31:0]};
        OFF_MTIMECMP_LO: mtimecmp_d = {mtimecmp_q[63:32], wdata};
        OFF_MTIMECMP_HI: mtimecmp_d = {wdata, mtimecmp_q[31:0]};
        OFF_CTRL:        ctrl_d = wdata[1:0];
        OFF_STATUS:      if (wdata[0]) pending_d = 1'b0;
        default:         ;
      endcase
    end
    // A live match overrides a software clear in the same cycle
    if (match && ctrl_q[CTRL_EN]) pending_d = 1'b1;
  end

  // Read mux: combinational, returns the pre-write value on a simultaneous store
  always_comb begin
    rdata = '0;
    if (re && hit) begin
      case (reg_off)
        OFF_MTIME_LO:    rdata = mtime_q[31:0];
        OFF_MTIME_HI:    rdata = mtime_q[63:32];
        OFF_MTIMECMP_LO: rdata = mtimecmp_q[31:0];
        OFF_MTIMECMP_HI: rdata = mtimecmp_q[63:32];
        OFF_CTRL:        rdata = {30'b0, ctrl_q};
        OFF_PRESCALE:    rdata = 32'(prescale);
        OFF_STATUS:      rdata = {31'b0, pending_q};
        default:         rdata = '0;
      endcase
    end
  end

  // Register-bank state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mtime_q    <= '0;
      mtimecmp_q <= MTIMECMP_RST;
      ctrl_q     <= '0;
      pending_q  <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      ctrl_q     <= ctrl_d;
      pending_q  <= pending_d;
    end
  end

endmodule

// File: doc/timer_irq_unit.md
Name: timer_irq_unit

Overview:
- Memory-mapped machine timer peripheral on the data-memory port of the 3-stage pipeline processor; lives beside data memory behind the address decoder.
- Provides a 64-bit free-running mtime with prescaler, a 64-bit mtimecmp, and a level timer-interrupt request into the processor's trap logic.
- Sits upstream of the processor's interrupt input.
- Sits downstream of its load/store stage.

Parameters:
- BASE_ADDR, 32'h8000_0000, byte base address of the register window (32-byte window).
- PRESCALE_W, 16, width of the prescaler reload register and counter.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  reset; asynchronous, active-low.
- addr  input  32  byte address from the memory stage; bits [1:0] ignored.
- wdata  input  32  store data.
- we  input  1  store strobe; qualified by window hit.
- re  input  1  load strobe; qualified by window hit.
- rdata  output  32  load data; combinational, same cycle as re.
- hit  output  1  addr within the window; used by the processor's data-memory mux.
- timer_irq  output  1  interrupt request to the processor; level.

Behaviour:
- Register map (offset from BASE_ADDR):
  - 0x00 MTIME_LO (RW)
  - 0x04 MTIME_HI (RW)
  - 0x08 MTIMECMP_LO (RW)
  - 0x0C MTIMECMP_HI (RW)
  - 0x10 CTRL (RW): bit0 = EN, bit1 = IRQ_EN
  - 0x14 PRESCALE (RW): [PRESCALE_W-1:0]
  - 0x18 STATUS: bit0 = PENDING; read; write-1-to-clear
  - 0x1C reserved: reads 0, writes ignored.
- Reset values:
  - mtime = 0
  - mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF
  - CTRL = 0
  - PRESCALE = 0
  - prescale counter = 0
  - PENDING = 0
  - timer_irq = 0
- rdata:
  - 0 when !(re && hit).
  - Otherwise the register selected by addr[4:2]. Unused bits read 0.
- Writes take effect on the posedge where we && hit. Only full-word writes are supported.
- Tick generation:
  - When EN = 1, the prescale counter decrements each cycle.
  - When the counter is 0, it reloads PRESCALE and asserts a one-cycle tick.
  - PRESCALE = 0 therefore ticks every cycle.
  - When EN = 0, the counter holds and no tick occurs.
  - Writing PRESCALE also reloads the counter with the new value.
- mtime increments by 1 on tick. It wraps from all-ones to 0 with no flag.
- Write to MTIME_LO or MTIME_HI in the same cycle as a tick:
  - The written half takes the write data.
  - The other half keeps its old value.
  - The tick is dropped, including any carry.
- Compare: match = (mtime >= mtimecmp), unsigned 64-bit, evaluated on registered values every cycle.
- PENDING set and clear:
  - Set on the posedge after match && EN.
  - Cleared only by a STATUS write with wdata[0] = 1.
  - If a clear and match are both true in the same cycle, set wins, so PENDING remains 1.
  - Disabling EN does not clear PENDING.
- timer_irq = PENDING && IRQ_EN, registered output (PENDING register gated by the CTRL register).
- Latency:
  - match to PENDING: 1 cycle.
  - IRQ_EN write to timer_irq change: visible the cycle after the write edge.
- Split writes to MTIMECMP:
  - Intermediate values are compared normally.
  - Software writes HI = all-ones first to avoid a spurious match. This is a software rule and needs no hardware protection.
- A simultaneous re and we to the same register reads the pre-write value.
- An asynchronous reset mid-count returns every register to its reset value immediately.
- There are no outstanding transactions to abort.

Decomposition:
- Shared package timer_pkg holds:
  - register offset constants: OFF_MTIME_LO .. OFF_STATUS
  - CTRL bit indices: CTRL_EN = 0, CTRL_IRQ_EN = 1
  - the reset constant for mtimecmp
- One natural sub-module: timer_prescaler, holding the reload register interface, down-counter and tick output, parameterised by PRESCALE_W.
- Everything else (register bank, mtime, compare, PENDING, read mux) stays in timer_irq_unit.

Test Plan:
1. Reset released, CTRL = 0x1, PRESCALE = 0, 10 cycles idle -> read MTIME_LO = 0x0000_000A ±1 per the write-edge alignment; timer_irq = 0.
2. PRESCALE = 3, EN = 1 -> mtime increments once every 4 cycles; after 40 cycles MTIME_LO = 0x0A.
3. MTIME_LO = 0xFFFF_FFFF, MTIME_HI = 0, PRESCALE = 0, EN = 1 -> one tick later MTIME_HI = 1 and MTIME_LO = 0; MTIME_HI = 0xFFFF_FFFF with LO all-ones wraps both halves to 0.
4. Interrupt sequence:
   - Setup: MTIMECMP_HI = 0, MTIMECMP_LO = 0x20, CTRL = 0x3, PRESCALE = 0.
   - Expected: PENDING and timer_irq rise the cycle after mtime reaches 0x20.
   - STATUS write 0x1 while mtime ≥ cmp -> PENDING stays 1.
   - Raise MTIMECMP_LO to 0x1000, then STATUS write 0x1 -> timer_irq = 0.
5. PENDING = 1 with CTRL = 0x1 (IRQ_EN = 0) -> timer_irq = 0, STATUS reads 0x1; then write CTRL = 0x3 -> timer_irq = 1 the next cycle.
6. Window decode and mid-operation reset:
   - Load from BASE_ADDR + 0x1C and from BASE_ADDR + 0x20 -> rdata = 0; hit = 1 for the first, 0 for the second.
   - Store to BASE_ADDR + 0x20 -> no register changes.
   - Assert rst mid-count -> all registers read their reset values.
